// File: rtl/hex_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : hex_seg_scan
//  Description : Time-multiplexed driver for a 4-digit common-anode 7-segment
//                display. It captures a whole frame of four segment patterns
//                at once, then scans the digits with a dark gap at the start
//                of every slot so that no digit shows ghosting.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_seg_scan #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] seg0,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic [6:0] seg3,
    output logic [6:0] seg_n,
    output logic [3:0] dig_n,
    output logic       frame_start
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);

    localparam logic [CNT_W-1:0] c_SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx;
    logic [3:0][6:0]   r_frame;
    logic [3:0][6:0]   w_frame;
    logic              w_capture;
    logic [6:0]        w_seg_n;
    logic [3:0]        w_dig_n;

    // Next-state, counter, digit index and frame capture; the drive values
    // are derived from the *next* state so outputs change together with it.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_frame   = r_frame;
        w_capture = 1'b0;
        w_seg_n   = 7'h7F;
        w_dig_n   = 4'hF;

        unique case (r_state)
            ST_OFF: begin
                w_cnt     = '0;
                w_idx     = 2'd0;
                w_state   = ST_BLANK;
                w_capture = 1'b1;
            end
            ST_BLANK: begin
                w_cnt = r_cnt + c_CNT_ONE;
                if (r_cnt == c_BLANK_LAST) begin
                    w_state = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (r_cnt == c_SLOT_LAST) begin
                    w_cnt   = '0;
                    w_idx   = r_idx + 2'd1;
                    w_state = ST_BLANK;
                    // Leaving the last digit starts a new frame.
                    w_capture = (r_idx == 2'd3);
                end else begin
                    w_cnt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state = ST_OFF;
                w_cnt   = '0;
                w_idx   = 2'd0;
            end
        endcase

        // Dropping enable overrides everything, including a pending capture.
        if (!enable) begin
            w_state   = ST_OFF;
            w_cnt     = '0;
            w_idx     = 2'd0;
            w_capture = 1'b0;
        end

        if (w_capture) begin
            w_frame = {seg3, seg2, seg1, seg0};
        end

        if (w_state == ST_SHOW) begin
            w_dig_n[w_idx] = 1'b0;
            w_seg_n        = ~w_frame[w_idx];
        end
    end

    // State, counters, frame store and all output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_OFF;
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_frame     <= '0;
            seg_n       <= 7'h7F;
            dig_n       <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_idx       <= w_idx;
            r_frame     <= w_frame;
            seg_n       <= w_seg_n;
            dig_n       <= w_dig_n;
            frame_start <= w_capture;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_seg_scan
//  Description : Self-checking bench for hex_seg_scan (SLOT=8, BLANK=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_seg_scan;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * SLOT;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [6:0] seg0, seg1, seg2, seg3;
    logic [6:0] seg_n;
    logic [3:0] dig_n;
    logic       frame_start;

    hex_seg_scan #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .seg0        (seg0),
        .seg1        (seg1),
        .seg2        (seg2),
        .seg3        (seg3),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       en;
        logic [6:0] s0, s1, s2, s3;
        int         n;
        logic [3:0] dig;
        logic [6:0] seg;
        logic       fs;
        logic       frame_zero;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    // Reference model: position inside a 32-cycle frame
    logic       m_on;
    int         m_t;
    logic [6:0] m_frame [4];
    logic       prev_fs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_step();
        exp_t       e;
        logic [3:0] one;
        int         d;
        int         pos;
        e.fs = 1'b0;
        if (reset) begin
            m_on = 1'b0;
            m_t  = 0;
            for (int i = 0; i < 4; i++) m_frame[i] = 7'h00;
        end else if (!enable) begin
            m_on = 1'b0;
            m_t  = 0;
        end else begin
            if (!m_on) begin
                m_on = 1'b1;
                m_t  = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
            if (m_t == 0) begin
                m_frame[0] = seg0; m_frame[1] = seg1;
                m_frame[2] = seg2; m_frame[3] = seg3;
                e.fs = 1'b1;
            end
        end
        d   = m_t / SLOT;
        pos = m_t % SLOT;
        e.dig = 4'hF;
        e.seg = 7'h7F;
        if (m_on && pos >= BLANK) begin
            one   = 4'b0001;
            e.dig = ~(one << d);
            e.seg = ~m_frame[d];
        end
        sb_q.push_back(e);
    endtask

    // One clock: predict, let the edge happen, compare at the falling edge.
    task automatic tick();
        exp_t e;
        int   lows;
        model_step();
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check("sb_dig_n", 32'(dig_n), 32'(e.dig));
        check("sb_seg_n", 32'(seg_n), 32'(e.seg));
        check("sb_frame_start", 32'(frame_start), 32'(e.fs));
        lows = 0;
        for (int i = 0; i < 4; i++) if (dig_n[i] == 1'b0) lows++;
        check("onehot_dig_n", 32'(lows <= 1), 32'd1);
        if (prev_fs) check("frame_start_width", 32'(frame_start), 32'd0);
        prev_fs = frame_start;
    endtask

    vec_t vecs [25];

    initial begin
        int lit3;
        int pulses;
        // rst en s0 s1 s2 s3 n  dig seg fs fz
        vecs[0]  = '{1, 0, 7'h3F, 7'h06, 7'h5B, 7'h4F, 2,  4'hF, 7'h7F, 0, 1};
        vecs[1]  = '{0, 1, 7'h3F, 7'h06, 7'h5B, 7'h4F, 1,  4'hF, 7'h7F, 1, 0};
        vecs[2]  = '{0, 1, 7'h3F, 7'h06, 7'h5B, 7'h4F, 1,  4'hF, 7'h7F, 0, 0};
        vecs[3]  = '{0, 1, 7'h3F, 7'h06, 7'h5B, 7'h4F, 1,  4'hE, 7'h40, 0, 0};
        vecs[4]  = '{0, 1, 7'h3F, 7'h06, 7'h5B, 7'h4F, 5,  4'hE, 7'h40, 0, 0};
        vecs[5]  = '{0, 1, 7'h3F, 7'h06, 7'h5B, 7'h4F, 1,  4'hF, 7'h7F, 0, 0};
        vecs[6]  = '{0, 1, 7'h3F, 7'h06, 7'h5B, 7'h4F, 2,  4'hD, 7'h79, 0, 0};
        vecs[7]  = '{0, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 8,  4'hB, 7'h24, 0, 0};
        vecs[8]  = '{0, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 8,  4'h7, 7'h30, 0, 0};
        vecs[9]  = '{0, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 6,  4'hF, 7'h7F, 1, 0};
        vecs[10] = '{0, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 2,  4'hE, 7'h00, 0, 0};
        vecs[11] = '{0, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 16, 4'hB, 7'h24, 0, 0};
        vecs[12] = '{0, 0, 7'h7F, 7'h06, 7'h5B, 7'h4F, 1,  4'hF, 7'h7F, 0, 0};
        vecs[13] = '{0, 0, 7'h7F, 7'h06, 7'h5B, 7'h4F, 3,  4'hF, 7'h7F, 0, 0};
        vecs[14] = '{0, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 1,  4'hF, 7'h7F, 1, 0};
        vecs[15] = '{0, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 2,  4'hE, 7'h00, 0, 0};
        vecs[16] = '{0, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 24, 4'h7, 7'h30, 0, 0};
        vecs[17] = '{1, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 1,  4'hF, 7'h7F, 0, 1};
        vecs[18] = '{0, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 1,  4'hF, 7'h7F, 1, 0};
        vecs[19] = '{0, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 2,  4'hE, 7'h00, 0, 0};
        vecs[20] = '{0, 1, 7'h7F, 7'h06, 7'h5B, 7'h4F, 29, 4'h7, 7'h30, 0, 0};
        vecs[21] = '{0, 0, 7'h7F, 7'h06, 7'h5B, 7'h4F, 1,  4'hF, 7'h7F, 0, 0};
        vecs[22] = '{0, 1, 7'h01, 7'h02, 7'h04, 7'h08, 1,  4'hF, 7'h7F, 1, 0};
        vecs[23] = '{0, 1, 7'h01, 7'h02, 7'h04, 7'h08, 2,  4'hE, 7'h7E, 0, 0};
        vecs[24] = '{0, 1, 7'h01, 7'h02, 7'h04, 7'h08, 8,  4'hD, 7'h7D, 0, 0};

        m_on    = 1'b0;
        m_t     = 0;
        prev_fs = 1'b0;
        for (int i = 0; i < 4; i++) m_frame[i] = 7'h00;
        reset = 1'b1; enable = 1'b0;
        seg0 = 7'h00; seg1 = 7'h00; seg2 = 7'h00; seg3 = 7'h00;

        // Table: apply inputs, run n clocks, compare the resulting snapshot.
        for (int v = 0; v < 25; v++) begin
            reset  = vecs[v].rst;
            enable = vecs[v].en;
            seg0 = vecs[v].s0; seg1 = vecs[v].s1;
            seg2 = vecs[v].s2; seg3 = vecs[v].s3;
            for (int c = 0; c < vecs[v].n; c++) tick();
            check($sformatf("vec%0d_dig_n", v), 32'(dig_n), 32'(vecs[v].dig));
            check($sformatf("vec%0d_seg_n", v), 32'(seg_n), 32'(vecs[v].seg));
            check($sformatf("vec%0d_frame_start", v), 32'(frame_start), 32'(vecs[v].fs));
            if (vecs[v].frame_zero) check($sformatf("vec%0d_frame_reg", v), 32'(dut.r_frame), 32'd0);
        end

        // Two full frames of free running: per-digit lit time and frame rate.
        lit3   = 0;
        pulses = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            if (dig_n == 4'h7) lit3++;
            if (frame_start) pulses++;
        end
        check("lit_cycles_digit3", 32'(lit3), 32'(2 * (SLOT - BLANK)));
        check("frame_pulses", 32'(pulses), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_seg_scan.md
HEX_SEG_SCAN -- requirements
Module: hex_seg_scan

Interface
REQ-001 Parameter SLOT_CYCLES, default 50000, clock cycles per digit slot; SHALL satisfy SLOT_CYCLES > BLANK_CYCLES + 1.
REQ-002 Parameter BLANK_CYCLES, default 64, dead-time cycles at the start of each slot with all digits off; SHALL be >= 1.
REQ-003 Port clk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port enable  input  1  1 = scan runs, 0 = display dark.
REQ-006 Ports seg0..seg3  input  7 each  segment patterns driven by the hex PIO out_port registers; bit i = segment i; 1 = lit.
REQ-007 Port seg_n  output  7  shared segment lines, active-low.
REQ-008 Port dig_n  output  4  digit selects, active-low, one-hot-low when lit.
REQ-009 Port frame_start  output  1  single-cycle pulse when a new frame is captured.
REQ-010 All outputs SHALL be registered, with no combinational path from inputs.

Function
REQ-011 The block SHALL hold a 4x7 frame register, a digit index idx (2 bits), a slot counter cnt, and a state in {OFF, BLANK, SHOW}.
REQ-012 OFF: dig_n=4'hF, seg_n=7'h7F, cnt=0, idx=0; when enable=1, the next state SHALL be BLANK with a frame capture.
REQ-013 Frame capture SHALL copy seg0..seg3 into the frame register in a single cycle and pulse frame_start for exactly that cycle.
REQ-014 BLANK: dig_n=4'hF and seg_n=7'h7F for BLANK_CYCLES cycles (cnt 0..BLANK_CYCLES-1), then SHOW.
REQ-015 SHOW: dig_n bit idx=0, other bits=1; seg_n=~frame[idx]; the state lasts until cnt=SLOT_CYCLES-1.
REQ-016 At the end of SHOW, cnt SHALL return to 0 and idx SHALL advance modulo 4, and the next state SHALL be BLANK.
REQ-017 The wrap from idx=3 to idx=0 SHALL perform a frame capture (REQ-013).
REQ-018 Input changes mid-frame SHALL NOT affect the displayed output until the next capture (no tearing).
REQ-019 Frame period SHALL be exactly 4*SLOT_CYCLES cycles, and lit time per digit SHALL be SLOT_CYCLES-BLANK_CYCLES cycles.
REQ-020 dig_n SHALL never have more than one bit low in any cycle.
REQ-021 The dig_n and seg_n registers SHALL update in the same cycle, so no digit is lit with the previous digit's pattern.
REQ-022 enable=0 in any state SHALL force OFF on the next cycle.
REQ-023 On that forced OFF, outputs SHALL go dark, idx=0 and cnt=0, and frame_start SHALL stay 0.
REQ-024 enable=0 and frame capture in the same cycle: enable=0 SHALL win, with no capture and no pulse.
REQ-025 The counter width SHALL be clog2(SLOT_CYCLES), and cnt SHALL never exceed SLOT_CYCLES-1.

Reset
REQ-026 With reset=1 at a clock edge, the next state SHALL be OFF, with dig_n=4'hF, seg_n=7'h7F, frame_start=0, idx=0, cnt=0 and frame register=0.
REQ-027 Reset SHALL take priority over enable, including when asserted mid-SHOW.
REQ-028 After reset deasserts with enable=1, the first frame capture SHALL occur on the first clock edge after deassertion.

Verification (SLOT_CYCLES=8, BLANK_CYCLES=2)
REQ-029 Reset, then enable=1 with seg0..3=7'h3F,06,5B,4F -> frame_start pulses once.
REQ-030 Continuing REQ-029 -> 2 dark cycles, then dig_n=4'hE and seg_n=7'h40 for 6 cycles, then 2 dark cycles, then dig_n=4'hD and seg_n=7'h79 for 6 cycles, continuing through digit 3; frame_start pulses every 32 cycles.
REQ-031 Change seg0 to 7'h7F while digit 1 is lit -> digit 0 keeps showing 7'h40 until after the next capture, then shows 7'h00.
REQ-032 Drop enable during digit 2 SHOW -> all outputs dark next cycle.
REQ-033 Continuing REQ-032, re-raise enable -> capture plus pulse, then the scan restarts at digit 0 after 2 dark cycles.
REQ-034 Assert reset for 1 cycle mid-SHOW of digit 3 -> outputs dark next cycle, and the frame register reads 0.
REQ-035 Continuing REQ-034 -> capture on the first edge after release.
REQ-036 All runs -> assertion checks that at most one dig_n bit is low, cnt stays below 8, and frame_start stays one cycle wide.
